// File: rtl/mat_mult_seq.sv
// mat_mult_seq: address/strobe sequencer for an NxN matrix multiply C=A*B.
// Define MM_PERF_CNT_EN to build the active/held cycle counters.
module mat_mult_seq #(
    parameter int N      = 8,
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hold,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic [AW-1:0] c_addr,
    output logic          c_we,
    output logic          busy,
    output logic          done,
    output logic [15:0]   cycle_count,
    output logic [15:0]   hold_count
);
    localparam int LN = $clog2(N);
    localparam int LW = AW + 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic [LN-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
    logic [LW-1:0] dl_q [RD_LAT];
    logic [LW-1:0] dl_in;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic          w_q, w_d;
    logic          adv, issue, term, pend;

    assign a_addr = {i_q, k_q};
    assign b_addr = {k_q, j_q};
    assign c_addr = c_addr_q;
    assign done   = state_q == DONE;

    always_comb begin
        busy  = state_q == RUN || state_q == DRAIN;
        adv   = !(hold && busy);
        issue = state_q == RUN && !hold;
        term  = &{i_q, j_q, k_q};
        pend  = 1'b0;
        for (int x = 0; x < RD_LAT; x++) pend = pend | dl_q[x][LW-1];
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = issue && term ? DRAIN : RUN;
            DRAIN:   state_d = !hold && !pend ? DONE : DRAIN;
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        k_d      = issue ? k_q + 1'b1 : k_q;
        j_d      = issue && &k_q ? j_q + 1'b1 : j_q;
        i_d      = issue && &{j_q, k_q} ? i_q + 1'b1 : i_q;
        dl_in    = {issue, k_q == '0, &k_q, i_q, j_q};
        mac_en   = dl_q[RD_LAT-1][LW-1] && adv;
        mac_clr  = mac_en && dl_q[RD_LAT-1][LW-2];
        // the write stage freezes with the rest so a held write is re-presented
        w_d      = adv ? mac_en && dl_q[RD_LAT-1][LW-3] : w_q;
        c_addr_d = mac_en && dl_q[RD_LAT-1][LW-3] ? dl_q[RD_LAT-1][AW-1:0] : c_addr_q;
        c_we     = w_q && adv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            w_q      <= 1'b0;
            c_addr_q <= '0;
            for (int x = 0; x < RD_LAT; x++) dl_q[x] <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            w_q      <= w_d;
            c_addr_q <= c_addr_d;
            if (adv) begin
                dl_q[0] <= dl_in;
                for (int x = 1; x < RD_LAT; x++) dl_q[x] <= dl_q[x-1];
            end
        end
    end

`ifdef MM_PERF_CNT_EN
    logic [15:0] cyc_q, hld_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start)) begin
            cyc_q <= '0;
            hld_q <= '0;
        end else if (busy) begin
            cyc_q <= cyc_q + {15'd0, ~&cyc_q};
            hld_q <= hld_q + {15'd0, hold && ~&hld_q};
        end
    end

    assign cycle_count = cyc_q;
    assign hold_count  = hld_q;
`else
    assign cycle_count = '0;
    assign hold_count  = '0;
`endif
endmodule

// File: tb/tb_mat_mult_seq.sv
// tb_mat_mult_seq: scoreboard bench for mat_mult_seq at RD_LAT=1 and RD_LAT=3.
module tb_mat_mult_seq;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset, start, hold;
    logic [AW-1:0] a1, b1, c1, a3, b3, c3;
    logic          me1, mc1, we1, busy1, done1, me3, mc3, we3, busy3, done3;
    logic [15:0]   cc1, hc1, cc3, hc3;

    always #5 clk = ~clk;

    mat_mult_seq #(.N(8), .AW(AW), .RD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .a_addr(a1), .b_addr(b1), .mac_en(me1), .mac_clr(mc1),
        .c_addr(c1), .c_we(we1), .busy(busy1), .done(done1),
        .cycle_count(cc1), .hold_count(hc1)
    );

    mat_mult_seq #(.N(8), .AW(AW), .RD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .a_addr(a3), .b_addr(b3), .mac_en(me3), .mac_clr(mc3),
        .c_addr(c3), .c_we(we3), .busy(busy3), .done(done3),
        .cycle_count(cc3), .hold_count(hc3)
    );

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, run_cyc = 0;
    logic [7:0]  mem_a [64], mem_b [64];
    logic [7:0]  ra, rb;
    logic [AW-1:0] as_q, bs_q;
    logic        frz = 1'b0;
    logic [63:0] exp_q [$];
    logic [63:0] e;
    int          acc = 0;
    int          n_me1, n_mc1, n_we1, n_we3, f_me1, f_we1, f_me3, f_mc3, f_we3;
    int          d1, d3;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input bit keep);
        int s;
        for (int ij = 0; ij < 64; ij++) begin
            s = 0;
            for (int k = 0; k < 8; k++) s += mem_a[(ij / 8) * 8 + k] * mem_b[k * 8 + ij % 8];
            exp_q.push_back({32'(ij), 32'(s)});
        end
        n_me1 = 0; n_mc1 = 0; n_we1 = 0; n_we3 = 0;
        f_me1 = -1; f_we1 = -1; f_me3 = -1; f_mc3 = -1; f_we3 = -1;
        start = 1'b1;
        tick(1);
        run_cyc = cyc;
        start = keep;
    endtask

    task automatic wait_done(output int r1, output int r3);
        r1 = -1;
        r3 = -1;
        for (int t = 0; t < 1000 && (r1 < 0 || r3 < 0); t++) begin
            @(negedge clk);
            if (done1 && r1 < 0) r1 = cyc - run_cyc;
            if (done3 && r3 < 0) r3 = cyc - run_cyc;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // operand RAMs stall together with the sequencer while hold is honoured
    always @(negedge clk) begin
        frz  <= hold && busy1;
        as_q <= a1;
        bs_q <= b1;
    end

    always @(posedge clk) begin
        if (!frz) begin
            ra <= mem_a[as_q];
            rb <= mem_b[bs_q];
        end
    end

    always @(negedge clk) begin
        if (hold && busy1) check("hold_strobe", {me1, mc1, we1}, 0);
        if (we1) begin
            n_we1++;
            if (f_we1 < 0) f_we1 = cyc - run_cyc;
            check("we_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("c_addr", c1, e[63:32]);
                check("c_val", acc, e[31:0]);
            end
        end
        if (me1) begin
            acc = mc1 ? ra * rb : acc + ra * rb;
            n_me1++;
            if (mc1) n_mc1++;
            if (f_me1 < 0) f_me1 = cyc - run_cyc;
        end
        if (me3 && f_me3 < 0) f_me3 = cyc - run_cyc;
        if (mc3 && f_mc3 < 0) f_mc3 = cyc - run_cyc;
        if (we3) begin
            n_we3++;
            if (f_we3 < 0) f_we3 = cyc - run_cyc;
        end
    end

    initial begin
        for (int x = 0; x < 64; x++) begin
            mem_a[x] = 8'($urandom);
            mem_b[x] = 8'($urandom);
        end
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        check("reset_u1", {a1, b1, c1, me1, mc1, we1, busy1, done1}, 0);
        check("reset_u3", {a3, b3, c3, me3, mc3, we3, busy3, done3}, 0);
        check("reset_cnt", {cc1, hc1, cc3, hc3}, 0);

        tick(1);
        launch(1'b0);
        tick(10);
        @(negedge clk);
        check("a_addr_n10", a1, 2);
        check("b_addr_n10", b1, 17);
        wait_done(d1, d3);
        check("done_lat1", d1, 514);
        check("done_lat3", d3, 516);
        check("mac_en_cnt", n_me1, 512);
        check("mac_clr_cnt", n_mc1, 64);
        check("c_we_cnt", n_we1, 64);
        check("sb_empty", exp_q.size(), 0);
        check("first_mac_en1", f_me1, 1);
        check("first_c_we1", f_we1, 9);
        check("first_mac_en3", f_me3, 3);
        check("first_mac_clr3", f_mc3, 3);
        check("first_c_we3", f_we3, 11);
        check("c_we_cnt3", n_we3, 64);
`ifdef MM_PERF_CNT_EN
        check("cycle_count", cc1, 514);
        check("hold_count", hc1, 0);
`else
        check("cycle_count", cc1, 0);
        check("hold_count", hc1, 0);
`endif

        tick(4);
        launch(1'b0);
        tick(7);
        hold = 1'b1;
        tick(2);
        @(negedge clk);
        check("hold_a_addr", a1, 7);
        check("hold_b_addr", b1, 56);
        tick(3);
        hold = 1'b0;
        wait_done(d1, d3);
        check("done_hold", d1, 519);
        check("first_c_we_hold", f_we1, 14);
        check("c_we_cnt_hold", n_we1, 64);
        check("sb_empty_hold", exp_q.size(), 0);
`ifdef MM_PERF_CNT_EN
        check("cycle_count_hold", cc1, 519);
        check("hold_count_hold", hc1, 5);
`else
        check("hold_count_hold", hc1, 0);
`endif

        tick(4);
        launch(1'b1);
        wait_done(d1, d3);
        check("done_keep", d1, 514);
        tick(20);
        @(negedge clk);
        check("done_sticky", done1, 1);
        check("no_restart", {busy1, busy3}, 0);
        check("no_second_run", n_me1, 512);
        start = 1'b0;
        tick(1);
        @(negedge clk);
        check("done_drop", {done1, done3}, 0);

        tick(2);
        launch(1'b0);
        tick(200);
        reset = 1'b1;
        exp_q.delete();
        n_we1 = 0;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_u1", {a1, b1, c1, me1, mc1, we1, busy1, done1}, 0);
        check("abort_u3", {a3, b3, c3, me3, mc3, we3, busy3, done3}, 0);
        tick(30);
        check("abort_no_we", n_we1, 0);
        launch(1'b0);
        wait_done(d1, d3);
        check("done_after_abort", d1, 514);
        check("c_we_after_abort", n_we1, 64);
        check("sb_empty_abort", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
